// File: rtl/mem_ctrl.sv
// Byte-serial controller between the IF/MEM pipeline stages and an 8-bit RAM.
// Arbitrates fetch vs load/store, walks the bytes of each access,
// assembles little-endian words and drives the stage stall lines.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_inst,
  output logic              if_done,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              ram_wr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [2:0]        len_reg, len_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       data_reg, data_next;
  logic              is_mem_reg, is_mem_next;
  logic [ADDR_W-1:0] ram_a_reg, ram_a_next;
  logic [7:0]        ram_dout_reg, ram_dout_next;
  logic              ram_wr_reg, ram_wr_next;
  logic [31:0]       if_inst_reg, if_inst_next;
  logic [31:0]       mem_rdata_reg, mem_rdata_next;
  logic              if_done_reg, if_done_next;
  logic              mem_done_reg, mem_done_next;

  // A freeze lets ram_din move on to the byte at the held ram_a, so the byte
  // that belonged to the previous address is parked here on the first frozen
  // cycle and used on resume instead of ram_din.
  logic              prev_rdy_reg;
  logic [7:0]        skid_reg;
  logic [7:0]        byte_in;
  logic [2:0]        cnt_p1;
  logic [4:0]        rd_sl;
  logic [4:0]        wr_sl;

  // Byte count of an access: byte, half, or word (size 3 behaves as word).
  function automatic logic [2:0] size_len(input logic [1:0] s);
    case (s)
      2'd0:    size_len = 3'd1;
      2'd1:    size_len = 3'd2;
      default: size_len = 3'd4;
    endcase
  endfunction

  // Next-state and datapath decisions for the request sequencer.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    len_next       = len_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    data_next      = data_reg;
    is_mem_next    = is_mem_reg;
    ram_a_next     = ram_a_reg;
    ram_dout_next  = ram_dout_reg;
    ram_wr_next    = 1'b0;
    if_inst_next   = if_inst_reg;
    mem_rdata_next = mem_rdata_reg;
    if_done_next   = 1'b0;
    mem_done_next  = 1'b0;
    byte_in        = prev_rdy_reg ? ram_din : skid_reg;
    cnt_p1         = cnt_reg + 3'd1;
    rd_sl          = {2'(cnt_reg - 3'd1), 3'b000};
    wr_sl          = {2'(cnt_p1), 3'b000};

    case (state_reg)
      IDLE: begin
        // Load/store wins: it belongs to the older instruction.
        if (mem_req) begin
          is_mem_next = 1'b1;
          addr_next   = mem_addr;
          len_next    = size_len(mem_size);
          wdata_next  = mem_wdata;
          cnt_next    = 3'd0;
          data_next   = 32'd0;
          ram_a_next  = mem_addr;
          if (mem_we) begin
            state_next    = WR;
            ram_dout_next = mem_wdata[7:0];
            ram_wr_next   = 1'b1;
          end else begin
            state_next = RD;
          end
        end else if (if_req) begin
          is_mem_next = 1'b0;
          addr_next   = if_addr;
          len_next    = 3'd4;
          cnt_next    = 3'd0;
          data_next   = 32'd0;
          ram_a_next  = if_addr;
          state_next  = RD;
        end
      end
      RD: begin
        // Cycle k presents addr+k; the byte for k-1 arrives this cycle.
        if (cnt_reg != 3'd0) begin
          data_next[rd_sl +: 8] = byte_in;
        end
        if (cnt_p1 < len_reg) begin
          ram_a_next = addr_reg + ADDR_W'(cnt_p1);
        end
        if (cnt_reg == len_reg) begin
          state_next = DONE;
          if (is_mem_reg) begin
            mem_rdata_next = data_next;
            mem_done_next  = 1'b1;
          end else begin
            if_inst_next = data_next;
            if_done_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_p1;
        end
      end
      WR: begin
        if (cnt_p1 < len_reg) begin
          ram_a_next    = addr_reg + ADDR_W'(cnt_p1);
          ram_dout_next = wdata_reg[wr_sl +: 8];
          ram_wr_next   = 1'b1;
          cnt_next      = cnt_p1;
        end else begin
          state_next    = DONE;
          mem_done_next = 1'b1;
        end
      end
      default: begin
        // DONE: requests are deliberately not sampled here.
        state_next = IDLE;
      end
    endcase
  end

  // State register; rdy low freezes everything, reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      len_reg       <= 3'd0;
      addr_reg      <= '0;
      wdata_reg     <= 32'd0;
      data_reg      <= 32'd0;
      is_mem_reg    <= 1'b0;
      ram_a_reg     <= '0;
      ram_dout_reg  <= 8'd0;
      ram_wr_reg    <= 1'b0;
      if_inst_reg   <= 32'd0;
      mem_rdata_reg <= 32'd0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
      prev_rdy_reg  <= 1'b1;
      skid_reg      <= 8'd0;
    end else begin
      prev_rdy_reg <= rdy;
      if (!rdy && prev_rdy_reg) begin
        skid_reg <= ram_din;
      end
      if (rdy) begin
        state_reg     <= state_next;
        cnt_reg       <= cnt_next;
        len_reg       <= len_next;
        addr_reg      <= addr_next;
        wdata_reg     <= wdata_next;
        data_reg      <= data_next;
        is_mem_reg    <= is_mem_next;
        ram_a_reg     <= ram_a_next;
        ram_dout_reg  <= ram_dout_next;
        ram_wr_reg    <= ram_wr_next;
        if_inst_reg   <= if_inst_next;
        mem_rdata_reg <= mem_rdata_next;
        if_done_reg   <= if_done_next;
        mem_done_reg  <= mem_done_next;
      end
    end
  end

  assign ram_a     = ram_a_reg;
  assign ram_dout  = ram_dout_reg;
  assign ram_wr    = ram_wr_reg & rdy;
  assign if_inst   = if_inst_reg;
  assign mem_rdata = mem_rdata_reg;
  assign if_done   = if_done_reg;
  assign mem_done  = mem_done_reg;
  assign if_stall  = if_req & ~if_done_reg;
  assign mem_stall = mem_req & ~mem_done_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, reference memory image,
// expected-write queue, per-cycle stall/write checks and latency checks.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_inst;
  logic        if_done;
  logic        if_stall;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        ram_wr;

  int errors = 0;
  int checks = 0;

  // RAM contents (low 16 address bits index it) and the expected image.
  bit   [7:0]  ram   [0:65535];
  bit   [7:0]  model [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'd0;
  logic [7:0]  pl_data = 8'd0;
  logic [39:0] wq[$];
  logic [39:0] wexp;
  logic [31:0] last_if = 32'd0;
  logic [31:0] last_mem = 32'd0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst),
    .if_done(if_done), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_stall(mem_stall),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din), .ram_wr(ram_wr)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  // Synchronous byte RAM: read data one cycle after the address.
  always @(posedge clk) begin
    ram_din <= ram[ram_a[15:0]];
    if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
    if (pl_en) ram[pl_addr] <= pl_data;
  end

  // Every-cycle checks: write stream, stall rule, freeze and exclusivity.
  always @(negedge clk) begin
    if (ram_wr) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", {ram_a, ram_dout}, 64'h0);
      end else begin
        wexp = wq.pop_front();
        chk("ram_write", {ram_a, ram_dout}, wexp);
      end
    end
    if (!rst) begin
      chk("if_stall", if_stall, if_req && !if_done);
      chk("mem_stall", mem_stall, mem_req && !mem_done);
      chk("both_done", if_done && mem_done, 1'b0);
      if (!rdy) chk("ram_wr_frozen", ram_wr, 1'b0);
    end
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    model[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Wait (bounded) for a done pulse, check latency and data, then drop req.
  task automatic wait_done(input bit is_mem, input int exp_lat, input bit chk_data,
                           input logic [31:0] exp_data, input string name);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat <= 200) begin
      @(negedge clk);
      if (is_mem ? mem_done : if_done) begin
        seen = 1'b1;
        if (chk_data) chk({name, "_data"}, is_mem ? mem_rdata : if_inst, exp_data);
        if (is_mem) last_mem = mem_rdata;
        else        last_if  = if_inst;
      end else begin
        lat++;
      end
    end
    chk({name, "_latency"}, lat, exp_lat);
    @(posedge clk); #1;
    if (is_mem) mem_req = 1'b0;
    else        if_req  = 1'b0;
  endtask

  // Drop rdy for len cycles starting at cycles after the request; ram_a must hold.
  task automatic freeze(input int at, input int len);
    logic [31:0] a0;
    repeat (at) @(posedge clk);
    #1 rdy = 1'b0;
    @(negedge clk);
    a0 = ram_a;
    repeat (len - 1) begin
      @(negedge clk);
      chk("frozen_ram_a", ram_a, a0);
    end
    @(posedge clk); #1;
    rdy = 1'b1;
  endtask

  // One request from an idle controller, expectations from the memory image.
  task automatic run_req(input bit is_mem, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int frz_at, input int frz_len, input string name);
    int n;
    logic [31:0] exp;
    logic [31:0] a;
    n   = !is_mem ? 4 : (size == 2'd0 ? 1 : (size == 2'd1 ? 2 : 4));
    exp = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      if (is_mem && we) begin
        wq.push_back({a, wdata[8*k +: 8]});
        model[a[15:0]] = wdata[8*k +: 8];
      end else begin
        exp = exp | (32'(model[a[15:0]]) << (8 * k));
      end
    end
    @(posedge clk); #1;
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    fork
      begin
        // Inputs are latched: scrambling them after acceptance must not matter.
        @(posedge clk); #2;
        mem_addr = ~addr; mem_wdata = ~wdata; if_addr = ~addr;
      end
    join_none
    if (frz_len > 0) begin
      fork
        freeze(frz_at, frz_len);
      join_none
    end
    wait_done(is_mem, ((is_mem && we) ? n + 1 : n + 2) + frz_len, !(is_mem && we), exp, name);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Memory image, loaded while reset is held.
    preload(16'h1000, 8'h13); preload(16'h1001, 8'h05);
    preload(16'h2000, 8'hEF); preload(16'h2001, 8'hBE);
    preload(16'h2002, 8'hAD); preload(16'h2003, 8'hDE);
    preload(16'h3003, 8'h77);
    preload(16'h4002, 8'h55); preload(16'h4003, 8'h66);
    preload(16'hFFFE, 8'h11); preload(16'hFFFF, 8'hA5);
    preload(16'h0000, 8'h22); preload(16'h0001, 8'h33);
    @(negedge clk);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_dout", ram_dout, 8'h0);
    chk("rst_ram_wr", ram_wr, 1'b0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_dones", {if_done, mem_done}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    run_req(1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, 0, 0, "fetch");
    chk("fetch_literal", last_if, 32'h00000513);

    // Fetch and word load raised together: load first, fetch right after.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h2000;
    fork
      wait_done(1'b1, 6, 1'b1, 32'hDEADBEEF, "simul_load");
      wait_done(1'b0, 13, 1'b1, 32'h00003322, "simul_fetch");
    join

    run_req(1'b1, 1'b1, 2'd1, 32'h3001, 32'h1234BEEF, 0, 0, "store_half");
    @(negedge clk);
    chk("st_3001", ram[16'h3001], 8'hEF);
    chk("st_3002", ram[16'h3002], 8'hBE);
    chk("st_3003_untouched", ram[16'h3003], 8'h77);

    run_req(1'b1, 1'b0, 2'd0, 32'hFFFFFFFF, 32'h0, 0, 0, "load_byte_top");
    chk("load_byte_literal", last_mem, 32'h000000A5);
    run_req(1'b1, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, 0, 0, "load_word_wrap");
    chk("load_wrap_literal", last_mem, 32'h3322A511);
    run_req(1'b1, 1'b0, 2'd1, 32'h2002, 32'h0, 0, 0, "load_half");
    run_req(1'b1, 1'b0, 2'd3, 32'h2000, 32'h0, 0, 0, "load_size3");
    run_req(1'b1, 1'b0, 2'd1, 32'h3001, 32'h0, 0, 0, "load_back_half");

    run_req(1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, 3, 3, "fetch_frozen");
    chk("fetch_frozen_literal", last_if, 32'h00000513);
    run_req(1'b1, 1'b1, 2'd2, 32'h5000, 32'h44332211, 2, 2, "store_frozen");
    run_req(1'b1, 1'b0, 2'd2, 32'h5000, 32'h0, 1, 3, "load_frozen");
    chk("load_frozen_literal", last_mem, 32'h44332211);

    // Reset in the middle of a word store, after two bytes have gone out.
    wq.push_back({32'h4000, 8'hAA});
    wq.push_back({32'h4001, 8'hBB});
    model[16'h4000] = 8'hAA;
    model[16'h4001] = 8'hBB;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2;
    mem_addr = 32'h4000; mem_wdata = 32'hDDCCBBAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ram_wr", ram_wr, 1'b0);
    chk("abort_ram_a", ram_a, 32'h0);
    chk("abort_ram_dout", ram_dout, 8'h0);
    chk("abort_rdata", mem_rdata, 32'h0);
    chk("abort_inst", if_inst, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_done", {mem_done, if_done}, 2'b00);
    end
    chk("abort_4002", ram[16'h4002], 8'h55);
    chk("abort_4001", ram[16'h4001], 8'hBB);

    run_req(1'b1, 1'b0, 2'd2, 32'h4000, 32'h0, 0, 0, "load_after_abort");
    chk("after_abort_literal", last_mem, 32'h6655BBAA);
    run_req(1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, 0, 0, "fetch_again");

    repeat (3) @(posedge clk);
    chk("writes_drained", wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
